seg_scan_reader: RTL and testbench
==================================

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive cycles a synchronized (an_n, seg_n) pair must be unchanged before capture; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port seg_n, input, 7 bits: sampled display segment lines, active-low, bit order {g,f,e,d,c,b,a}, asynchronous to clk.
REQ-005 SHALL have port an_n, input, 4 bits: sampled digit enables, active-low, bit i selects digit i, asynchronous to clk.
REQ-006 SHALL have port digits, output, 16 bits: recovered frame, digit i in bits [4i+3:4i]; values 0-9 are decoded digits and 4'hF means blank or invalid.
REQ-007 SHALL have port digit_err, output, 4 bits: bit i is set when digit i of the presented frame held an undecodable pattern.
REQ-008 SHALL have port frame_valid, output, 1 bit: a presented frame is pending.
REQ-009 SHALL have port frame_ack, input, 1 bit: the consumer accepts the pending frame.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag; an unacknowledged frame was overwritten.

Function
REQ-011 SHALL pass seg_n and an_n through a 2-flop synchronizer before any other use.
REQ-012 SHALL hold stab_cnt at 0 on any cycle where the synchronized pair differs from the previous cycle's pair, and otherwise increment it, saturating at STABLE_CYCLES-1.
REQ-013 SHALL use a 2-state FSM with states WAIT and HELD; any change of the synchronized pair forces WAIT.
REQ-014 SHALL, when in WAIT with stab_cnt == STABLE_CYCLES-1 and exactly one an_n bit low (digit k), capture on that edge: decode seg_n into shadow slot k, set error bit k, set seen[k], and go to HELD.
REQ-015 SHALL perform exactly one capture per dwell; HELD performs no capture until the pair changes.
REQ-016 SHALL, for a single held input change, produce the capture on rising edge STABLE_CYCLES+2 after the change.
REQ-017 SHALL ignore, with no capture and seen unchanged, a stable an_n that is all ones (blanking) or has more than one bit low.
REQ-018 SHALL decode the ten patterns 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10 to 0-9 with err=0, decode 0x7F (all off) to 4'hF with err=0, and decode any other pattern to 4'hF with err=1.
REQ-019 SHALL, on the edge where seen becomes 4'b1111, copy the shadow slots into digits and digit_err, set frame_valid, and clear seen to 0 on that same edge.
REQ-020 SHALL clear frame_valid on the edge where frame_ack=1 and frame_valid=1; frame_ack is ignored while frame_valid=0.
REQ-021 SHALL, when a frame completes while frame_valid=1 and frame_ack=0, overwrite digits and digit_err, keep frame_valid=1, and set overrun.
REQ-022 SHALL, when frame_ack and a frame completion coincide, give the new frame priority (frame_valid stays 1) and leave overrun unchanged.
REQ-023 SHALL clear overrun only on an accepted frame_ack.
REQ-024 SHALL hold digits and digit_err stable whenever no frame completes.
REQ-025 SHALL let a recaptured slot overwrite its shadow value while seen is incomplete.

Reset
REQ-026 SHALL, on rst high, immediately set digits=16'hFFFF, digit_err=0, frame_valid=0, overrun=0, seen=0, stab_cnt=0, FSM=WAIT, and synchronizer flops to all ones (idle/blank).
REQ-027 SHALL discard any partial frame when rst is asserted mid-frame; after release, capture restarts from an empty seen mask.

Structure
REQ-028 SHALL place the ten segment pattern constants, the blank pattern 7'h7F, and the code BLANK_CODE=4'hF in shared package seg_pkg, which is also used by the existing segment encoder.
REQ-029 SHALL implement the inverse table as one combinational sub-module, seg_pattern_decode (seg_n[6:0] -> digit[3:0], err).

Verification
REQ-030 SHALL verify: each of an_n=1110,1101,1011,0111 held 20 cycles with patterns for 1,2,3,4 -> one frame_valid, digits=16'h4321, digit_err=0.
REQ-031 SHALL verify: digit 2 driven with pattern 0x7E -> digits[11:8]=F and digit_err=4'b0100; pattern 0x7F -> F with err=0.
REQ-032 SHALL verify: a glitch of STABLE_CYCLES-1 cycles between valid dwells -> no capture and no seen change from the glitch.
REQ-033 SHALL verify: two full frames with no ack -> second frame visible, overrun=1; an ack then clears frame_valid and overrun.
REQ-034 SHALL verify: frame_ack asserted on the completion edge -> frame_valid stays 1 and overrun stays 0.
REQ-035 SHALL verify: rst pulse after 3 digits captured -> outputs at reset values, and the next frame requires all 4 digits.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns used by
// the segment encoder and by the scan reader's inverse table.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } scan_state_t;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic an_one_low(input logic [3:0] an_n);
    return ($countones(~an_n) == 1);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the segment encoder: pattern -> digit code plus error.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = BLANK_CODE;
    err   = 1'b0;
    case (seg_n)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = BLANK_CODE;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Recovers a 4-digit frame from a multiplexed seven-segment display by sampling
// each digit dwell once it has been stable, and presents it with a valid/ack handshake.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        overrun
);

  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_REACH = 8'(STABLE_CYCLES - 2);

  logic [6:0]  r_seg_s1, r_seg_s2, r_seg_prev;
  logic [3:0]  r_an_s1, r_an_s2, r_an_prev;
  logic [7:0]  r_stab_cnt;
  scan_state_t r_state;
  logic [3:0]  r_seen;
  logic [15:0] r_shadow;
  logic [3:0]  r_shadow_err;

  logic        w_chg, w_sel_ok, w_capture, w_frame_done, w_ack_ok;
  logic [1:0]  w_k;
  logic [3:0]  w_dec_digit;
  logic        w_dec_err;
  logic [3:0]  w_seen_nxt;
  logic [15:0] w_merge_dig;
  logic [3:0]  w_merge_err;

  // Synchronizer idles at all ones so reset looks like a blanked display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
    end
  end

  seg_pattern_decode u_decode (
    .seg_n (r_seg_s2),
    .digit (w_dec_digit),
    .err   (w_dec_err)
  );

  assign w_chg    = ({r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev});
  assign w_sel_ok = an_one_low(r_an_s2);
  assign w_k      = an_index(r_an_s2);
  assign w_ack_ok = frame_ack && frame_valid;

  // Capture on the edge where the stability counter reaches STABLE_CYCLES-1.
  assign w_capture = (r_state == ST_WAIT) && !w_chg && (r_stab_cnt == CNT_REACH) && w_sel_ok;

  always_comb begin
    w_seen_nxt  = r_seen;
    w_merge_dig = r_shadow;
    w_merge_err = r_shadow_err;
    if (w_capture) begin
      w_seen_nxt[w_k]                = 1'b1;
      w_merge_dig[{w_k, 2'b00} +: 4] = w_dec_digit;
      w_merge_err[w_k]               = w_dec_err;
    end
  end

  assign w_frame_done = w_capture && (w_seen_nxt == 4'b1111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_prev  <= '1;
      r_seg_prev <= '1;
      r_stab_cnt <= '0;
      r_state    <= ST_WAIT;
    end else begin
      r_an_prev  <= r_an_s2;
      r_seg_prev <= r_seg_s2;
      if (w_chg)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != CNT_MAX)
        r_stab_cnt <= r_stab_cnt + 8'd1;
      if (w_chg)
        r_state <= ST_WAIT;
      else if (w_capture)
        r_state <= ST_HELD;
    end
  end

  // A completing frame wins over a coincident ack; overrun only flags a real loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen       <= '0;
      r_shadow     <= {4{BLANK_CODE}};
      r_shadow_err <= '0;
      digits       <= {4{BLANK_CODE}};
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_shadow     <= w_merge_dig;
      r_shadow_err <= w_merge_err;
      if (w_frame_done) begin
        r_seen      <= '0;
        digits      <= w_merge_dig;
        digit_err   <= w_merge_err;
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ack)
          overrun <= 1'b1;
      end else begin
        r_seen <= w_seen_nxt;
        if (w_ack_ok) begin
          frame_valid <= 1'b0;
          overrun     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scenario bench for seg_scan_reader: expected frames are queued as digits are
// driven and compared by a monitor whenever a new frame is presented.
module tb_seg_scan_reader;

  localparam int SC = 4;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_ack;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  err;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      m_exp;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_err = 4'h0;
  logic        m_vld = 1'b0;

  seg_scan_reader #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Every newly presented frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_valid === 1'b1 && (!m_vld || digits !== m_dig || digit_err !== m_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_frame: got digits=%h err=%b, required no frame", digits, digit_err);
      end else begin
        m_exp = exp_q.pop_front();
        if (digits !== m_exp.dig || digit_err !== m_exp.err)
          $display("FAIL frame_data: got digits=%h err=%b, required digits=%h err=%b",
                   digits, digit_err, m_exp.dig, m_exp.err);
        else
          n_pass++;
      end
    end
    m_vld = (frame_valid === 1'b1);
    m_dig = digits;
    m_err = digit_err;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [6:0] p0, input logic [6:0] p1,
                             input logic [6:0] p2, input logic [6:0] p3);
    dwell(4'b1110, p0, 20);
    dwell(4'b1101, p1, 20);
    dwell(4'b1011, p2, 20);
    dwell(4'b0111, p3, 20);
    dwell(4'b1111, 7'h7F, 6);
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_ack = 1'b0; an_n = 4'hF; seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (digits !== 16'hFFFF) $display("FAIL rst_digits: got %h, required ffff", digits); else n_pass++;
    n_checks++; if (digit_err !== 4'h0) $display("FAIL rst_err: got %b, required 0000", digit_err); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b, required 0", overrun); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    exp_q.push_back({16'h4321, 4'b0000});
    drive_frame(PAT[1], PAT[2], PAT[3], PAT[4]);
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL basic_valid: got %b, required 1", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b, required 0", overrun); else n_pass++;
    ack_pulse();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL basic_ack: got %b, required 0", frame_valid); else n_pass++;
    n_checks++; if (digits !== 16'h4321) $display("FAIL basic_hold: got %h, required 4321", digits); else n_pass++;
  endtask

  task automatic test_err();
    exp_q.push_back({16'h7F65, 4'b0100});
    drive_frame(PAT[5], PAT[6], 7'h7E, PAT[7]);
    n_checks++; if (digit_err !== 4'b0100) $display("FAIL err_bad_pattern: got %b, required 0100", digit_err); else n_pass++;
    ack_pulse();
    exp_q.push_back({16'h0F98, 4'b0000});
    drive_frame(PAT[8], PAT[9], 7'h7F, PAT[0]);
    n_checks++; if (digits[11:8] !== 4'hF) $display("FAIL err_blank_code: got %h, required f", digits[11:8]); else n_pass++;
    n_checks++; if (digit_err !== 4'b0000) $display("FAIL err_blank_flag: got %b, required 0000", digit_err); else n_pass++;
    ack_pulse();
  endtask

  task automatic test_glitch();
    dwell(4'b1110, PAT[1], 20);
    dwell(4'b1101, PAT[2], SC - 1);
    dwell(4'b1110, PAT[1], 20);
    dwell(4'b1011, PAT[3], 20);
    dwell(4'b0111, PAT[4], 20);
    dwell(4'b0011, PAT[5], 20);
    dwell(4'b1111, PAT[6], 20);
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL glitch_no_frame: got %b, required 0", frame_valid); else n_pass++;
    exp_q.push_back({16'h4391, 4'b0000});
    dwell(4'b1101, PAT[9], 20);
    dwell(4'b1111, 7'h7F, 6);
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL glitch_frame: got %b, required 1", frame_valid); else n_pass++;
    ack_pulse();
  endtask

  task automatic test_overrun();
    exp_q.push_back({16'h1234, 4'b0000});
    drive_frame(PAT[4], PAT[3], PAT[2], PAT[1]);
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_first: got %b, required 0", overrun); else n_pass++;
    exp_q.push_back({16'h5678, 4'b0000});
    drive_frame(PAT[8], PAT[7], PAT[6], PAT[5]);
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL ovr_valid: got %b, required 1", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b, required 1", overrun); else n_pass++;
    ack_pulse();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b, required 0", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b, required 0", overrun); else n_pass++;
  endtask

  task automatic test_ack_coincide();
    exp_q.push_back({16'h2222, 4'b0000});
    drive_frame(PAT[2], PAT[2], PAT[2], PAT[2]);
    exp_q.push_back({16'h9876, 4'b0000});
    dwell(4'b1110, PAT[6], 20);
    dwell(4'b1101, PAT[7], 20);
    dwell(4'b1011, PAT[8], 20);
    // Capture lands on the sixth edge after the change; ack rides that edge.
    dwell(4'b0111, PAT[9], SC + 1);
    ack_pulse();
    dwell(4'b0111, PAT[9], 10);
    dwell(4'b1111, 7'h7F, 6);
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL coinc_valid: got %b, required 1", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL coinc_overrun: got %b, required 0", overrun); else n_pass++;
    ack_pulse();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL coinc_ack: got %b, required 0", frame_valid); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    exp_q.push_back({16'hF000, 4'b1000});
    drive_frame(PAT[0], PAT[0], PAT[0], 7'h7E);
    n_checks++; if (digit_err !== 4'b1000) $display("FAIL mid_err_before: got %b, required 1000", digit_err); else n_pass++;
    dwell(4'b1110, PAT[1], 20);
    dwell(4'b1101, PAT[1], 20);
    dwell(4'b1011, PAT[1], 20);
    dwell(4'b1111, 7'h7F, 6);
    rst = 1'b1;
    #2;
    n_checks++; if (digits !== 16'hFFFF) $display("FAIL mid_rst_digits: got %h, required ffff", digits); else n_pass++;
    n_checks++; if (digit_err !== 4'h0) $display("FAIL mid_rst_err: got %b, required 0000", digit_err); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", frame_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL mid_rst_overrun: got %b, required 0", overrun); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dwell(4'b0111, PAT[3], 20);
    dwell(4'b1111, 7'h7F, 6);
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL mid_partial: got %b, required 0", frame_valid); else n_pass++;
    exp_q.push_back({16'h3555, 4'b0000});
    dwell(4'b1110, PAT[5], 20);
    dwell(4'b1101, PAT[5], 20);
    dwell(4'b1011, PAT[5], 20);
    dwell(4'b1111, 7'h7F, 6);
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL mid_refill: got %b, required 1", frame_valid); else n_pass++;
    ack_pulse();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_glitch();
    test_overrun();
    test_ack_coincide();
    test_reset_midframe();
    repeat (4) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL frames_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
